// File: rtl/fifo_uart_tx_if.sv
// Byte-producer side of the buffered UART transmitter: write strobe/data in,
// FIFO status (full, empy, count, overflow) and UART line (tx, tx_busy) out.
interface fifo_uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             wr;
    logic [7:0]       datin;
    logic             full;
    logic             empy;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             tx;
    logic             tx_busy;

    modport master (
        output wr, datin,
        input  full, empy, count, overflow, tx, tx_busy
    );

    modport slave (
        input  wr, datin,
        output full, empy, count, overflow, tx, tx_busy
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Buffered 8N1 UART transmitter: bytes written through bus.wr/bus.datin are
// queued in a FIFO and shifted out LSB first on bus.tx, CLK_DIV clocks per bit.
// Ports: clk, reset (async, active-low), bus (slave: wr, datin -> full, empy,
// count, overflow, tx, tx_busy).
module fifo_uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.slave  bus
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLK_DIV);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_n;
    logic               r_full;
    logic               r_empy;
    logic               r_overflow;
    logic [BAUD_W-1:0]  r_baud;
    logic [BAUD_W-1:0]  w_baud_n;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_n;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_n;
    logic               r_tx;
    logic               w_tx_n;
    logic               w_push;
    logic               w_pop;
    logic               w_last;

    assign w_last = (r_baud == BAUD_LAST);
    assign w_push = bus.wr && !r_full;

    // Serializer next state; a pop reloads the shift register and starts
    // a new frame directly from STOP so bursts have no idle gap.
    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_tx_n    = r_tx;
        w_pop     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_tx_n = 1'b1;
                if (!r_empy) begin
                    w_pop     = 1'b1;
                    w_shift_n = r_mem[r_rptr];
                    w_tx_n    = 1'b0;
                    w_baud_n  = '0;
                    w_state_n = START;
                end
            end
            START: begin
                if (w_last) begin
                    w_tx_n    = r_shift[0];
                    w_bit_n   = '0;
                    w_baud_n  = '0;
                    w_state_n = DATA;
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
            DATA: begin
                if (w_last) begin
                    w_baud_n = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_n    = 1'b1;
                        w_state_n = STOP;
                    end else begin
                        w_bit_n   = r_bit + 1'b1;
                        w_shift_n = {1'b0, r_shift[7:1]};
                        w_tx_n    = r_shift[1];
                    end
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
            STOP: begin
                if (w_last) begin
                    w_baud_n = '0;
                    if (!r_empy) begin
                        w_pop     = 1'b1;
                        w_shift_n = r_mem[r_rptr];
                        w_tx_n    = 1'b0;
                        w_state_n = START;
                    end else begin
                        w_state_n = IDLE;
                    end
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
        end
    end

    always_comb begin
        w_count_n = r_count;
        if (w_push && !w_pop) begin
            w_count_n = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_n = r_count - 1'b1;
        end
    end

    // Status flags are registered from the next count so they move on
    // the same edge as the push/pop that changes occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empy     <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (bus.wr && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_n;
            r_full  <= (w_count_n == CNT_FULL);
            r_empy  <= (w_count_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.datin;
        end
    end

    assign bus.tx       = r_tx;
    assign bus.tx_busy  = (r_state != IDLE);
    assign bus.full     = r_full;
    assign bus.empy     = r_empy;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (CLK_DIV=4, FIFO_DEPTH=16): line-level
// frame checks, burst timing, overflow, reset abort and pointer wrap.
module tb_fifo_uart_tx;
    localparam int DIV   = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;

    fifo_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus();

    fifo_uart_tx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int         n_chk   = 0;
    int         n_err   = 0;
    int         rx_ferr = 0;
    logic [7:0] rxq[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] rx_next();
        if (rxq.size() > 0) return {1'b0, rxq.pop_front()};
        return 9'h100;
    endfunction

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (!(bus.empy && !bus.tx_busy) && n < bound) begin
            tick();
            n++;
        end
        check("drain_done", n < bound, 1);
        repeat (4) tick();
    endtask

    // UART receiver model: samples mid-bit on negedges
    initial begin
        logic       act;
        int         pos;
        int         idx;
        logic [7:0] sh;
        act = 1'b0;
        pos = 0;
        sh  = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                act = 1'b0;
            end else begin
                if (!act && bus.tx === 1'b0) begin
                    act = 1'b1;
                    pos = 0;
                end else if (act) begin
                    pos++;
                end
                if (act && (pos % DIV) == DIV / 2) begin
                    idx = pos / DIV;
                    if (idx == 0) begin
                        if (bus.tx !== 1'b0) begin
                            rx_ferr++;
                            act = 1'b0;
                        end
                    end else if (idx <= 8) begin
                        sh[idx-1] = bus.tx;
                    end else begin
                        if (bus.tx !== 1'b1) rx_ferr++;
                        rxq.push_back(sh);
                        act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] obs;
        logic [39:0] expv;
        logic [9:0]  pat;
        logic [7:0]  burst [3];
        int          n;
        int          bad;
        int          hi;

        reset     = 1'b0;
        bus.wr    = 1'b0;
        bus.datin = '0;

        // 1: reset state
        repeat (3) tick();
        check("rst_tx", bus.tx, 1);
        check("rst_empy", bus.empy, 1);
        check("rst_full", bus.full, 0);
        check("rst_count", bus.count, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_busy", bus.tx_busy, 0);
        #2 reset = 1'b1;
        repeat (3) tick();

        // 2: single byte 0xA5
        rxq.delete();
        bus.wr    = 1'b1;
        bus.datin = 8'hA5;
        tick();
        bus.wr    = 1'b0;
        bus.datin = 8'h00;
        check("s_count_k", bus.count, 1);
        check("s_empy_k", bus.empy, 0);
        check("s_busy_k", bus.tx_busy, 0);
        check("s_tx_k", bus.tx, 1);
        tick();
        check("s_tx_k1", bus.tx, 0);
        check("s_busy_k1", bus.tx_busy, 1);
        check("s_empy_k1", bus.empy, 1);
        check("s_count_k1", bus.count, 0);
        obs[0] = bus.tx;
        for (int i = 1; i < 40; i++) begin
            tick();
            obs[i] = bus.tx;
        end
        check("s_busy_k40", bus.tx_busy, 1);
        tick();
        check("s_busy_k41", bus.tx_busy, 0);
        check("s_tx_k41", bus.tx, 1);
        pat = 10'b1_1010_0101_0;
        for (int i = 0; i < 40; i++) expv[i] = pat[i/DIV];
        check("s_line", obs, expv);
        repeat (4) tick();
        check("s_rx_n", rxq.size(), 1);
        check("s_rx_byte", rx_next(), 9'h0A5);

        // 3: back-to-back burst
        rxq.delete();
        burst[0] = 8'h00;
        burst[1] = 8'hFF;
        burst[2] = 8'h55;
        bus.wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.datin = burst[i];
            tick();
        end
        bus.wr = 1'b0;
        n = 2;
        while (bus.tx_busy && n < 300) begin
            tick();
            n++;
        end
        check("b_len", n, 121);
        wait_drain(200);
        check("b_rx_n", rxq.size(), 3);
        check("b_rx0", rx_next(), 9'h000);
        check("b_rx1", rx_next(), 9'h0FF);
        check("b_rx2", rx_next(), 9'h055);

        // 4: overflow
        rxq.delete();
        bus.wr = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.datin = 8'(i);
            tick();
            if (i == 16) begin
                check("o_count16", bus.count, 16);
                check("o_full16", bus.full, 1);
                check("o_ovf16", bus.overflow, 0);
            end
            if (i == 17) begin
                check("o_count17", bus.count, 16);
                check("o_full17", bus.full, 1);
                check("o_ovf17", bus.overflow, 1);
            end
        end
        bus.wr = 1'b0;
        wait_drain(17 * 40 + 100);
        check("o_rx_n", rxq.size(), 17);
        bad = 0;
        for (int i = 0; i < 17; i++) begin
            if (rx_next() !== 9'(i)) bad++;
        end
        check("o_rx_order", bad, 0);
        check("o_ovf_sticky", bus.overflow, 1);

        // 5: reset mid-frame
        rxq.delete();
        bus.wr    = 1'b1;
        bus.datin = 8'h3C;
        tick();
        bus.datin = 8'h11;
        tick();
        bus.datin = 8'h22;
        tick();
        bus.wr = 1'b0;
        repeat (16) tick();
        check("r_bit3", bus.tx, 1);
        check("r_count_pre", bus.count, 2);
        #2 reset = 1'b0;
        #1;
        check("r_tx", bus.tx, 1);
        check("r_empy", bus.empy, 1);
        check("r_count", bus.count, 0);
        check("r_busy", bus.tx_busy, 0);
        check("r_ovf", bus.overflow, 0);
        tick();
        #2 reset = 1'b1;
        hi = 1;
        repeat (100) begin
            tick();
            if (bus.tx !== 1'b1) hi = 0;
        end
        check("r_line_idle", hi, 1);
        check("r_busy_after", bus.tx_busy, 0);
        check("r_rx_n", rxq.size(), 0);

        // 6: pointer wrap, 4 bursts of 10
        rxq.delete();
        for (int b = 0; b < 4; b++) begin
            bus.wr = 1'b1;
            for (int i = 0; i < 10; i++) begin
                bus.datin = 8'((b * 10 + i) * 37 + 5);
                tick();
            end
            bus.wr = 1'b0;
            wait_drain(10 * 40 + 100);
        end
        check("w_rx_n", rxq.size(), 40);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (rx_next() !== {1'b0, 8'(i * 37 + 5)}) bad++;
        end
        check("w_rx_order", bad, 0);
        check("frame_errs", rx_ferr, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
